fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 50 +++++
 rtl/fetch_watchdog.sv | 44 ++++
 rtl/fetch_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the fetch sequencer, its watchdog and the datapath
// decoder: opcode values, the sequencer state encoding, the fetch watchdog
// limit, and small helpers that split an instruction byte into its fields.
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

  // Sequencer states. Eight states fit exactly in three bits.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DECODE  = 3'd3,
    ST_EXEC    = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_HALT    = 3'd6,
    ST_ERROR   = 3'd7
  } seqState_t;

  // Opcodes handled by the sequencer itself. Every other opcode value is
  // handed to the datapath.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Number of consecutive WAIT cycles without read data that counts as a
  // dead memory, and the counter width needed to reach it.
  localparam int WATCHDOG_LIMIT = 8;
  localparam int WATCHDOG_WIDTH = $clog2(WATCHDOG_LIMIT);

  // Upper nibble of an instruction byte is the opcode.
  function automatic logic [3:0] opcodeOf(input logic [7:0] instr);
    return instr[7:4];
  endfunction

  // Lower nibble of an instruction byte is the operand (jump target).
  function automatic logic [3:0] operandOf(input logic [7:0] instr);
    return instr[3:0];
  endfunction

  // True when the opcode must be executed by the datapath rather than
  // being resolved entirely inside the sequencer.
  function automatic logic isDatapathOp(input logic [3:0] opcode);
    return !((opcode == OP_NOP) || (opcode == OP_JMP) ||
             (opcode == OP_JZ)  || (opcode == OP_HLT));
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// ---------------------------------------------------------------------------
// fetch_watchdog
// Counts consecutive cycles spent waiting for program memory. Flags expiry
// in the cycle that would be the WATCHDOG_LIMIT-th consecutive wait.
//
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset, clears the count
//   i_clear    clears the count (asserted while fetching a new address)
//   i_countEn  one more wait cycle without data
//   o_expired  this wait cycle is the last one allowed; no data arrived
// ---------------------------------------------------------------------------
module fetch_watchdog
  import fetch_sequencer_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_countEn,
  output logic o_expired
);

  localparam logic [WATCHDOG_WIDTH-1:0] LAST_COUNT =
    WATCHDOG_WIDTH'(WATCHDOG_LIMIT - 1);

  logic [WATCHDOG_WIDTH-1:0] r_count;

  // The count only advances on wait cycles that saw no data, so a response
  // arriving in the final allowed cycle keeps i_countEn low and therefore
  // never raises o_expired. The counter is cleared on every new fetch so the
  // limit applies per read request rather than accumulating across them.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_countEn) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is decided combinationally so the sequencer can enter ERROR at
  // the end of the limit-th empty wait cycle rather than one cycle later.
  assign o_expired = i_countEn && (r_count == LAST_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch/dispatch sequencer for a small 4-bit-address machine.
// Fetches a byte from program memory at the current PC, resolves NOP, JMP,
// JZ and HLT itself, dispatches every other opcode to the datapath, and
// steers the external program counter with increment/load strobes.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous active-high reset
//   RUN        start/continue; sampled in IDLE and at the end of each instr
//   PC_COUNT   current program counter value
//   PC_EN      one-cycle increment strobe to the program counter
//   PC_PRGM    one-cycle load strobe to the program counter
//   PC_LOAD    value loaded into the program counter with PC_PRGM
//   MEM_ADDR   program memory read address
//   MEM_RD     program memory read request, held until MEM_VALID
//   MEM_DATA   program memory read data
//   MEM_VALID  qualifies MEM_DATA
//   ZERO       datapath zero flag, consulted by JZ
//   IR         latched instruction byte
//   EXEC_STB   one-cycle dispatch pulse for datapath instructions
//   EXEC_DONE  datapath completion of the dispatched instruction
//   HALTED     sequencer stopped by HLT
//   FAULT      sequencer stopped by a memory watchdog timeout
// ---------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RUN,
  input  logic [3:0] PC_COUNT,
  output logic       PC_EN,
  output logic       PC_PRGM,
  output logic [3:0] PC_LOAD,
  output logic [3:0] MEM_ADDR,
  output logic       MEM_RD,
  input  logic [7:0] MEM_DATA,
  input  logic       MEM_VALID,
  input  logic       ZERO,
  output logic [7:0] IR,
  output logic       EXEC_STB,
  input  logic       EXEC_DONE,
  output logic       HALTED,
  output logic       FAULT
);

  seqState_t r_state;
  seqState_t w_nextState;

  logic       r_pcEn;
  logic       r_pcPrgm;
  logic [3:0] r_pcLoad;
  logic [3:0] r_memAddr;
  logic       r_memRd;
  logic [7:0] r_ir;
  logic       r_execStb;
  logic       r_halted;
  logic       r_fault;

  logic       w_pcEn;
  logic       w_pcPrgm;
  logic [3:0] w_pcLoad;
  logic [3:0] w_memAddr;
  logic       w_memRd;
  logic [7:0] w_ir;
  logic       w_execStb;
  logic       w_halted;
  logic       w_fault;

  logic       w_wdogClear;
  logic       w_wdogCountEn;
  logic       w_wdogExpired;
  logic [3:0] w_opcode;
  logic [3:0] w_operand;

  assign w_opcode      = opcodeOf(r_ir);
  assign w_operand     = operandOf(r_ir);
  assign w_wdogClear   = (r_state == ST_FETCH);
  assign w_wdogCountEn = (r_state == ST_WAIT) && !MEM_VALID;

  fetch_watchdog u_watchdog (
    .i_clk     (CLK),
    .i_reset   (RESET),
    .i_clear   (w_wdogClear),
    .i_countEn (w_wdogCountEn),
    .o_expired (w_wdogExpired)
  );

  // Next-state and next-output logic. Every output is registered, so each
  // branch describes what the outputs should be during the state being
  // entered. Strobes default low so they only last one cycle unless a
  // branch re-asserts them. The cycle that carries a PC strobe (PC_EN for
  // NOP/not-taken JZ/datapath ops, PC_PRGM for taken jumps) is always the
  // ADVANCE state; RUN is sampled at its end, which is what lets a dropped
  // RUN finish the current instruction and only then park in IDLE. Holding
  // the PC strobe in its own state also guarantees the counter has updated
  // before the following FETCH samples PC_COUNT.
  always_comb begin
    w_nextState = r_state;
    w_pcEn      = 1'b0;
    w_pcPrgm    = 1'b0;
    w_pcLoad    = 4'h0;
    w_memAddr   = r_memAddr;
    w_memRd     = 1'b0;
    w_ir        = r_ir;
    w_execStb   = 1'b0;
    w_halted    = 1'b0;
    w_fault     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (RUN) begin
          w_nextState = ST_FETCH;
        end
      end

      ST_FETCH: begin
        w_memAddr   = PC_COUNT;
        w_memRd     = 1'b1;
        w_nextState = ST_WAIT;
      end

      ST_WAIT: begin
        if (MEM_VALID) begin
          w_ir        = MEM_DATA;
          w_nextState = ST_DECODE;
        end else if (w_wdogExpired) begin
          w_fault     = 1'b1;
          w_nextState = ST_ERROR;
        end else begin
          w_memRd     = 1'b1;
        end
      end

      ST_DECODE: begin
        if (w_opcode == OP_HLT) begin
          w_halted    = 1'b1;
          w_nextState = ST_HALT;
        end else if ((w_opcode == OP_JMP) ||
                     ((w_opcode == OP_JZ) && ZERO)) begin
          w_pcPrgm    = 1'b1;
          w_pcLoad    = w_operand;
          w_nextState = ST_ADVANCE;
        end else if (isDatapathOp(w_opcode)) begin
          w_execStb   = 1'b1;
          w_nextState = ST_EXEC;
        end else begin
          w_pcEn      = 1'b1;
          w_nextState = ST_ADVANCE;
        end
      end

      ST_EXEC: begin
        if (EXEC_DONE) begin
          w_pcEn      = 1'b1;
          w_nextState = ST_ADVANCE;
        end
      end

      ST_ADVANCE: begin
        w_nextState = RUN ? ST_FETCH : ST_IDLE;
      end

      ST_HALT: begin
        w_halted = 1'b1;
      end

      ST_ERROR: begin
        w_fault = 1'b1;
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset is checked first so it overrides RUN,
  // MEM_VALID and EXEC_DONE arriving in the same cycle, and it pulls the
  // sequencer back to IDLE from any state, including HALT and ERROR which
  // otherwise never exit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_pcEn    <= 1'b0;
      r_pcPrgm  <= 1'b0;
      r_pcLoad  <= 4'h0;
      r_memAddr <= 4'h0;
      r_memRd   <= 1'b0;
      r_ir      <= 8'h00;
      r_execStb <= 1'b0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_pcEn    <= w_pcEn;
      r_pcPrgm  <= w_pcPrgm;
      r_pcLoad  <= w_pcLoad;
      r_memAddr <= w_memAddr;
      r_memRd   <= w_memRd;
      r_ir      <= w_ir;
      r_execStb <= w_execStb;
      r_halted  <= w_halted;
      r_fault   <= w_fault;
    end
  end

  assign PC_EN    = r_pcEn;
  assign PC_PRGM  = r_pcPrgm;
  assign PC_LOAD  = r_pcLoad;
  assign MEM_ADDR = r_memAddr;
  assign MEM_RD   = r_memRd;
  assign IR       = r_ir;
  assign EXEC_STB = r_execStb;
  assign HALTED   = r_halted;
  assign FAULT    = r_fault;

endmodule
